// File: rtl/lfsr_bus_ctrl.sv
// Round-robin sequencer for the LFSR data slave: address, compare,
// capture strobe, timed bus drive and ack/err back to the requester.
module lfsr_bus_ctrl #(
    parameter int ADDR_W = 4,
    parameter int HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              A_eq_Faddr,
    output logic [ADDR_W-1:0] a,
    output logic              q1_id,
    output logic              D_en,
    output logic              lfsr_step,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LOAD,
        DRIVE,
        MISS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              g_q, g_d;
    logic              rr_q, rr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            g_q     <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        g_d     = g_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // both requesting: the round-robin pointer decides
                    win     = (req == 2'b11) ? rr_q : req[1];
                    g_d     = win;
                    a_d     = win ? addr1 : addr0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = A_eq_Faddr ? LOAD : MISS;
            end
            LOAD: begin
                cnt_d   = CNT_LAST;
                state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            MISS: begin
                state_d = DONE;
            end
            DONE: begin
                rr_d    = ~g_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic [1:0] onehot;
    logic       active;
    logic       drv;

    assign onehot = g_q ? 2'b10 : 2'b01;
    assign active = (state_q != IDLE) && (state_q != DONE);
    assign drv    = (state_q == DRIVE);

    // outputs depend only on registered state, never on req/A_eq_Faddr
    assign a         = a_q;
    assign busy      = active;
    assign gnt       = active ? onehot : 2'b00;
    assign q1_id     = (state_q == LOAD);
    assign D_en      = drv;
    assign lfsr_step = drv && (cnt_q == CNT_LAST);
    assign ack       = (drv && (cnt_q == 4'd0)) ? onehot : 2'b00;
    assign err       = (state_q == MISS) ? onehot : 2'b00;

endmodule

// File: tb/tb_lfsr_bus_ctrl.sv
// Scoreboarded bench for lfsr_bus_ctrl: HOLD=2 main instance plus
// HOLD=4 (mid-drive reset) and HOLD=1 (single drive cycle) builds.
module tb_lfsr_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_err;
        logic        idx;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic        rst_n;
    logic [1:0]  req;
    logic [3:0]  addr0, addr1, faddr;
    logic [3:0]  a;
    logic        aeq, q1_id, d_en, step, busy;
    logic [1:0]  gnt, ack, err;
    logic [31:0] src, cap;

    assign aeq = (a == faddr);

    lfsr_bus_ctrl #(.ADDR_W(4), .HOLD(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .addr0(addr0), .addr1(addr1), .A_eq_Faddr(aeq),
        .a(a), .q1_id(q1_id), .D_en(d_en), .lfsr_step(step),
        .gnt(gnt), .ack(ack), .err(err), .busy(busy)
    );

    // slave capture register model
    always @(posedge clk) if (q1_id) cap <= src;

    logic        rst4_n;
    logic [1:0]  req4;
    logic [3:0]  a4;
    logic        aeq4, q4, den4, st4, busy4;
    logic [1:0]  gnt4, ack4, err4;
    int          ack4_cnt = 0;

    assign aeq4 = (a4 == faddr);

    lfsr_bus_ctrl #(.ADDR_W(4), .HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst4_n), .req(req4),
        .addr0(addr0), .addr1(addr1), .A_eq_Faddr(aeq4),
        .a(a4), .q1_id(q4), .D_en(den4), .lfsr_step(st4),
        .gnt(gnt4), .ack(ack4), .err(err4), .busy(busy4)
    );

    always @(negedge clk) if (ack4 != 2'b00) ack4_cnt++;

    logic [1:0]  req1;
    logic [3:0]  a1;
    logic        aeq1, q11, den1, st1, busy1;
    logic [1:0]  gnt1, ack1, err1;

    assign aeq1 = (a1 == faddr);

    lfsr_bus_ctrl #(.ADDR_W(4), .HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .addr0(addr0), .addr1(addr1), .A_eq_Faddr(aeq1),
        .a(a1), .q1_id(q11), .D_en(den1), .lfsr_step(st1),
        .gnt(gnt1), .ack(ack1), .err(err1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // monitor: pops an expectation whenever the main DUT responds
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ack != 2'b00 || err != 2'b00)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp ack=%b err=%b required=none",
                         ack, err);
            end else begin
                e = exp_q.pop_front();
                chk("resp_ack", 32'(ack),
                    e.is_err ? 32'd0 : (e.idx ? 32'd2 : 32'd1));
                chk("resp_err", 32'(err),
                    e.is_err ? (e.idx ? 32'd2 : 32'd1) : 32'd0);
                if (!e.is_err)
                    chk("resp_data", d_en ? cap : 32'h0, e.data);
            end
        end
    end

    // one transaction on the main DUT, entered and left on an IDLE negedge
    task automatic txn(input logic [1:0] r, input logic widx,
                       input logic hit, input logic [31:0] data,
                       input logic drop);
        src = data;
        req = r;
        exp_q.push_back('{is_err: !hit, idx: widx, data: data});
        @(negedge clk);
        chk("gnt_addr", 32'(gnt), widx ? 32'd2 : 32'd1);
        chk("a_addr", 32'(a), 32'(widx ? addr1 : addr0));
        chk("busy_addr", 32'(busy), 32'd1);
        if (drop) req = 2'b00;
        @(negedge clk);
        chk("q1_id", 32'(q1_id), 32'(hit));
        chk("den_pre", 32'(d_en), 32'd0);
        if (hit) begin
            @(negedge clk);
            chk("den_d1", 32'(d_en), 32'd1);
            chk("step_d1", 32'(step), 32'd1);
            @(negedge clk);
            chk("den_d2", 32'(d_en), 32'd1);
            chk("step_d2", 32'(step), 32'd0);
        end
        @(negedge clk);
        chk("gnt_done", 32'(gnt), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("den_done", 32'(d_en), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        req    = 2'b00;
        req4   = 2'b00;
        req1   = 2'b00;
        addr0  = 4'h5;
        addr1  = 4'h3;
        faddr  = 4'h5;
        src    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {27'd0, q1_id, d_en, step, ack != 2'b00,
                         err != 2'b00}, 32'd0);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        txn(2'b01, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        txn(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        addr1 = 4'h5;
        txn(2'b11, 1'b0, 1'b1, 32'h11111111, 1'b0);
        txn(2'b11, 1'b1, 1'b1, 32'h22222222, 1'b0);
        txn(2'b11, 1'b0, 1'b1, 32'h33333333, 1'b0);
        txn(2'b11, 1'b1, 1'b1, 32'h44444444, 1'b0);
        txn(2'b01, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // HOLD=4: complete one to move rr to 1, then abort the next
        req4 = 2'b01;
        @(negedge clk);
        req4 = 2'b00;
        repeat (5) @(negedge clk);
        chk("h4_ack", 32'(ack4), 32'd1);
        repeat (2) @(negedge clk);
        req4 = 2'b01;
        @(negedge clk);
        req4 = 2'b00;
        repeat (3) @(negedge clk);
        chk("h4_den_pre_rst", 32'(den4), 32'd1);
        rst4_n = 1'b0;
        #1;
        chk("h4_den_rst", 32'(den4), 32'd0);
        chk("h4_gnt_rst", 32'(gnt4), 32'd0);
        chk("h4_busy_rst", 32'(busy4), 32'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("h4_no_ack", 32'(ack4_cnt), 32'd1);
        req4 = 2'b11;
        @(negedge clk);
        chk("h4_gnt_rr0", 32'(gnt4), 32'd1);
        req4 = 2'b00;
        repeat (5) @(negedge clk);
        chk("h4_ack2", 32'(ack4), 32'd1);
        chk("h4_den_last", 32'(den4), 32'd1);

        // HOLD=1: step and ack share the single drive cycle
        req1 = 2'b01;
        @(negedge clk);
        chk("h1_gnt", 32'(gnt1), 32'd1);
        req1 = 2'b00;
        @(negedge clk);
        chk("h1_q1", 32'(q11), 32'd1);
        @(negedge clk);
        chk("h1_drive", {29'd0, den1, st1, ack1[0]}, 32'd7);
        @(negedge clk);
        chk("h1_after", {29'd0, den1, ack1}, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
